// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - self-seeding checker for the 16-bit LFSR byte stream
// Predicts random[0] from its own history and counts mismatches while locked.
module lfsr_stream_checker #(
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [7:0]  random_i,
    input  logic        clear_i,
    output logic        locked_o,
    output logic        err_pulse_o,
    output logic [15:0] err_count_o,
    output logic        shift_err_o
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic {ST_SEED, ST_CHECK} state_t;

    state_t             state_q;
    logic [15:0]        hist_q;
    logic [3:0]         seed_cnt_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [ERR_W-1:0]   win_err_q;
    logic [6:0]         prev_q;
    logic               prev_vld_q;
    logic               err_pulse_q;
    logic [15:0]        err_count_q;
    logic               shift_err_q;

    logic               bit_d;
    logic               pred_d;
    logic               mismatch_d;
    logic [15:0]        seed_hist_d;
    logic [ERR_W-1:0]   win_err_d;

    always_comb begin
        bit_d       = random_i[0];
        pred_d      = hist_q[10] ^ hist_q[12] ^ hist_q[13] ^ hist_q[15];
        mismatch_d  = bit_d != pred_d;
        seed_hist_d = {hist_q[14:0], bit_d};
        win_err_d   = win_err_q + ERR_W'(mismatch_d);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_SEED;
            hist_q      <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            shift_err_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (en_i) begin
                prev_q     <= random_i[6:0];
                prev_vld_q <= 1'b1;
                if (prev_vld_q && (random_i[7:1] != prev_q)) begin
                    shift_err_q <= 1'b1;
                end
                case (state_q)
                    ST_SEED: begin
                        hist_q <= seed_hist_d;
                        if (seed_cnt_q == 4'd15) begin
                            seed_cnt_q <= '0;
                            // an all-zero seed would predict zeros forever; keep seeding
                            if (seed_hist_d != '0) begin
                                state_q <= ST_CHECK;
                            end
                        end else begin
                            seed_cnt_q <= seed_cnt_q + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        // feed back the prediction so one bad bit costs one error only
                        hist_q <= {hist_q[14:0], pred_d};
                        if (mismatch_d) begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != 16'hFFFF) begin
                                err_count_q <= err_count_q + 16'd1;
                            end
                        end
                        if (win_err_d >= ERR_W'(ERR_LIMIT)) begin
                            state_q    <= ST_SEED;
                            seed_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            win_err_q  <= '0;
                        end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + WIN_W'(1);
                            win_err_q <= win_err_d;
                        end
                    end
                    default: state_q <= ST_SEED;
                endcase
            end
            if (clear_i) begin
                err_count_q <= '0;
                shift_err_q <= 1'b0;
            end
        end
    end

    assign locked_o    = (state_q == ST_CHECK);
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;
    assign shift_err_o = shift_err_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb/tb_lfsr_stream_checker.sv - scoreboard bench for lfsr_stream_checker
// Driver pushes model expectations per cycle; monitor pops and compares after each edge.
module tb_lfsr_stream_checker;

    localparam int WINDOW    = 64;
    localparam int ERR_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [7:0]  random_i = '0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic        err_pulse_o;
    logic [15:0] err_count_o;
    logic        shift_err_o;

    always #5 clk = ~clk;

    lfsr_stream_checker #(.WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .random_i    (random_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .err_pulse_o (err_pulse_o),
        .err_count_o (err_count_o),
        .shift_err_o (shift_err_o)
    );

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic        serr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;

    // reference model state
    bit       m_locked;
    bit       m_hist[$];
    int       m_seed, m_win, m_werr, m_cnt;
    bit       m_serr, m_pulse, m_prev_vld;
    bit [7:0] m_prev;

    // generator
    logic [15:0] g;
    bit          entropy = 1'b0;

    function automatic void model_step(bit rst_n, bit en, bit [7:0] rnd, bit clr);
        bit d, p, any;
        if (!rst_n) begin
            m_locked = 0; m_seed = 0; m_win = 0; m_werr = 0; m_cnt = 0;
            m_serr = 0; m_pulse = 0; m_prev_vld = 0; m_prev = '0;
            m_hist = {};
            for (int i = 0; i < 16; i++) m_hist.push_back(1'b0);
            return;
        end
        m_pulse = 0;
        if (en) begin
            d = rnd[0];
            p = m_hist[10] ^ m_hist[12] ^ m_hist[13] ^ m_hist[15];
            if (m_prev_vld && rnd[7:1] != m_prev[6:0]) m_serr = 1;
            m_prev = rnd;
            m_prev_vld = 1;
            if (!m_locked) begin
                m_hist.push_front(d);
                void'(m_hist.pop_back());
                m_seed++;
                if (m_seed == 16) begin
                    m_seed = 0;
                    any = 0;
                    foreach (m_hist[i]) any |= m_hist[i];
                    if (any) m_locked = 1;
                end
            end else begin
                m_hist.push_front(p);
                void'(m_hist.pop_back());
                if (d != p) begin
                    m_pulse = 1;
                    if (m_cnt < 65535) m_cnt++;
                    m_werr++;
                end
                m_win++;
                if (m_werr >= ERR_LIMIT) begin
                    m_locked = 0; m_seed = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WINDOW) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (clr) begin
            m_cnt = 0;
            m_serr = 0;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.locked = m_locked;
        e.pulse  = m_pulse;
        e.cnt    = 16'(m_cnt);
        e.serr   = m_serr;
        sb.push_back(e);
    endfunction

    task automatic rst_cycle();
        @(negedge clk);
        rst_i = 1'b0; en_i = 1'b0; clear_i = 1'b0; random_i = '0;
        model_step(0, 0, '0, 0);
        push_exp();
    endtask

    task automatic step(input bit en, input bit clr, input bit flip, input bit zero);
        logic [7:0] rnd;
        @(negedge clk);
        rnd = random_i;
        if (en) begin
            g = {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10] ^ entropy};
            rnd = zero ? 8'h00 : (g[11:4] ^ {7'b0, flip});
        end
        rst_i = 1'b1; en_i = en; clear_i = clr; random_i = rnd;
        model_step(1, en, rnd, clr);
        push_exp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic dcheck(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (err_pulse_o) pulse_cnt++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({locked_o, err_pulse_o, err_count_o, shift_err_o} != e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got locked=%0b pulse=%0b cnt=%0d serr=%0b expected locked=%0b pulse=%0b cnt=%0d serr=%0b",
                         $time, locked_o, err_pulse_o, err_count_o, shift_err_o,
                         e.locked, e.pulse, e.cnt, e.serr);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        bit saw_drop;

        for (int i = 0; i < 3; i++) rst_cycle();
        settle();
        dcheck("reset_locked", locked_o, 0);
        dcheck("reset_count", err_count_o, 0);
        dcheck("reset_shift_err", shift_err_o, 0);

        g = 16'h0001;
        run(15);
        settle();
        dcheck("not_locked_after_15", locked_o, 0);
        run(1);
        settle();
        dcheck("locked_after_16", locked_o, 1);

        run(2000);
        settle();
        dcheck("clean_count", err_count_o, 0);
        dcheck("clean_shift_err", shift_err_o, 0);

        p0 = pulse_cnt;
        step(1, 0, 1, 0);
        run(30);
        settle();
        dcheck("flip_count", err_count_o, 1);
        dcheck("flip_pulses", pulse_cnt - p0, 1);
        dcheck("flip_locked", locked_o, 1);
        dcheck("flip_shift_err", shift_err_o, 1);

        step(1, 1, 0, 0);
        settle();
        dcheck("clear_count", err_count_o, 0);
        dcheck("clear_shift_err", shift_err_o, 0);

        entropy = 1'b1;
        saw_drop = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            settle();
            if (!locked_o) saw_drop = 1;
        end
        entropy = 1'b0;
        dcheck("entropy_drop", int'(saw_drop), 1);
        run(150);
        settle();
        dcheck("entropy_relock", locked_o, 1);

        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 49) == 0), 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        run(100);
        step(1, 1, 1, 0);
        settle();
        dcheck("clear_wins_count", err_count_o, 0);
        run(50);

        rst_cycle();
        for (int i = 0; i < 100; i++) step(1, 0, 0, 1);
        settle();
        dcheck("zero_never_locks", locked_o, 0);

        rst_cycle();
        g = 16'hACE1;
        run(40);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1, 0);
            run(40);
        end
        settle();
        dcheck("five_errors", err_count_o, 5);
        dcheck("five_locked", locked_o, 1);
        rst_cycle();
        settle();
        dcheck("midrst_locked", locked_o, 0);
        dcheck("midrst_count", err_count_o, 0);
        run(15);
        settle();
        dcheck("midrst_not_yet", locked_o, 0);
        run(1);
        settle();
        dcheck("midrst_relock", locked_o, 1);
        run(5);
        settle();
        settle();
        dcheck("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
